// File: rtl/sha_pad.sv
// sha_pad: SHA-1/SHA-256 message padder and 512-bit block framer for the hash core.
// Optional SHA_PAD_SWAP_EN byte-reverses host words on acceptance (little-endian host).
module sha_pad #(
    parameter int          CNT_W    = 32,
    parameter logic [2:0]  FIN_DONE = 3'b010
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    input  logic        in_last,
    input  logic [1:0]  in_bytes,
    output logic        in_ready,
    output logic [1:0]  start,
    output logic [31:0] data,
    input  logic [2:0]  finished,
    output logic        msg_done
);
    typedef enum logic [2:0] {IDLE, DATA, PAD, ZERO, LEN_HI, LEN_LO, WAIT} state_t;
    state_t            state_q, state_d, tgt_q, tgt_d, pad_nxt;
    logic [3:0]        idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic [1:0]        start_q, start_d;
    logic [31:0]       data_q, data_d;
    logic              done_q, done_d;
    logic [31:0]       word, pad_word;
    logic [2:0]        nb;
    logic [5:0]        add_bits;
    logic [63:0]       len;
    logic [1:0]        code;
`ifdef SHA_PAD_SWAP_EN
    assign word = {in_data[7:0], in_data[15:8], in_data[23:16], in_data[31:24]};
`else
    assign word = in_data;
`endif
    assign nb       = (in_bytes == 2'b00) ? 3'd4 : {1'b0, in_bytes};
    assign pad_word = (word & ~(32'hFFFF_FFFF >> {nb, 3'b000})) | (32'h8000_0000 >> {nb, 3'b000});
    assign add_bits = in_last ? {nb, 3'b000} : 6'd32;
    assign code     = (idx_q == 4'd0) ? 2'b01 : (idx_q == 4'd15) ? 2'b11 : 2'b10;
    // Where to go after the 0x80 byte is placed: overflow into an extra block when it lands at 14 or 15.
    assign pad_nxt  = (idx_q == 4'd15) ? WAIT : (idx_q == 4'd13) ? LEN_HI : ZERO;
    assign in_ready = reset && (state_q == IDLE || state_q == DATA);
    assign start    = start_q;
    assign data     = data_q;
    assign msg_done = done_q;
    always_comb begin
        len = '0;
        len[CNT_W-1:0] = cnt_q;
    end
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        start_d = 2'b00;
        data_d  = '0;
        done_d  = 1'b0;
        case (state_q)
            IDLE, DATA: begin
                if (in_valid) begin
                    start_d = code;
                    idx_d   = idx_q + 4'd1;
                    cnt_d   = cnt_q + CNT_W'(add_bits);
                    data_d  = word;
                    state_d = DATA;
                    if (in_last && nb != 3'd4) begin
                        data_d  = pad_word;
                        state_d = pad_nxt;
                        ovf_d   = idx_q == 4'd14;
                        tgt_d   = ZERO;
                    end else if (in_last) begin
                        state_d = (idx_q == 4'd15) ? WAIT : PAD;
                        tgt_d   = PAD;
                    end else if (idx_q == 4'd15) begin
                        state_d = WAIT;
                        tgt_d   = DATA;
                    end
                end
            end
            PAD: begin
                start_d = code;
                idx_d   = idx_q + 4'd1;
                data_d  = 32'h8000_0000;
                state_d = pad_nxt;
                ovf_d   = idx_q == 4'd14;
                tgt_d   = ZERO;
            end
            ZERO: begin
                start_d = code;
                idx_d   = idx_q + 4'd1;
                state_d = (idx_q == 4'd15) ? WAIT : (idx_q == 4'd13 && !ovf_q) ? LEN_HI : ZERO;
                ovf_d   = ovf_q && idx_q != 4'd15;
                tgt_d   = ZERO;
            end
            LEN_HI: begin
                start_d = code;
                idx_d   = idx_q + 4'd1;
                data_d  = len[63:32];
                state_d = LEN_LO;
            end
            LEN_LO: begin
                start_d = code;
                idx_d   = idx_q + 4'd1;
                data_d  = len[31:0];
                state_d = WAIT;
                tgt_d   = IDLE;
            end
            WAIT: begin
                if (finished == FIN_DONE) begin
                    state_d = tgt_q;
                    done_d  = tgt_q == IDLE;
                    cnt_d   = (tgt_q == IDLE) ? '0 : cnt_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            tgt_q   <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            start_q <= 2'b00;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            start_q <= start_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_sha_pad.sv
// tb_sha_pad: random-stimulus bench comparing sha_pad output against a byte-level SHA padding model.
module tb_sha_pad;
    localparam logic [2:0] FIN = 3'b010;
    logic        clk = 1'b0, reset = 1'b0, in_valid = 1'b0, in_last = 1'b0;
    logic [31:0] in_data = '0;
    logic [1:0]  in_bytes = '0;
    logic [2:0]  finished = '0;
    logic        in_ready, msg_done;
    logic [1:0]  start;
    logic [31:0] data;
    int          n_cmp = 0, n_bad = 0;
    byte unsigned msg_q[$];
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    sha_pad dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_bytes(in_bytes), .in_ready(in_ready), .start(start), .data(data),
        .finished(finished), .msg_done(msg_done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic make_msg(input int len);
        msg_q.delete();
        for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
    endtask

    // Standard padding on the byte stream: 0x80, zeros to 56 mod 64, 64-bit big-endian bit length.
    task automatic build_exp();
        byte unsigned p[$];
        logic [63:0]  bits;
        p = msg_q;
        bits = 64'(32'(msg_q.size() * 8));
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(8'(bits >> (8 * i)));
        exp_q.delete();
        for (int i = 0; i < p.size(); i += 4) exp_q.push_back({p[i], p[i+1], p[i+2], p[i+3]});
    endtask

    task automatic drive_word(input int w);
        byte unsigned b[4];
        int           left;
        left = msg_q.size() - 4 * w;
        for (int k = 0; k < 4; k++) b[k] = (k < left) ? msg_q[4*w+k] : 8'($urandom);
`ifdef SHA_PAD_SWAP_EN
        in_data = {b[3], b[2], b[1], b[0]};
`else
        in_data = {b[0], b[1], b[2], b[3]};
`endif
        in_last  = left <= 4;
        in_bytes = (left >= 4) ? 2'd0 : 2'(left);
        in_valid = 1'b1;
    endtask

    task automatic run_msg(input int abort_at, input int bub);
        int ptr, seen, dones, fin_cnt, nwords, v;
        bit pending, aborted;
        ptr = 0; seen = 0; dones = 0; fin_cnt = 0; pending = 0; aborted = 0;
        nwords = (msg_q.size() + 3) / 4;
        build_exp();
        for (int cyc = 0; cyc < 4000 && dones == 0 && !aborted; cyc++) begin
            @(negedge clk);
            if (pending) begin
                check("wait_start", start, 0);
                check("wait_ready", in_ready, 0);
            end
            if (start != 2'b00) begin
                if (seen < exp_q.size()) begin
                    check("start", start, (seen % 16 == 0) ? 1 : (seen % 16 == 15) ? 3 : 2);
                    check("data", data, exp_q[seen]);
                end else check("extra_word", seen, exp_q.size());
                seen++;
                if (start == 2'b11) begin
                    pending = 1;
                    fin_cnt = int'($urandom_range(0, 12));
                end
            end
            if (msg_done) begin
                dones++;
                check("done_words", seen, exp_q.size());
            end
            if (abort_at >= 0 && seen == abort_at) begin
                reset = 1'b0; in_valid = 1'b0; finished = '0;
                @(negedge clk);
                check("abort_start", start, 0);
                check("abort_ready", in_ready, 0);
                check("abort_done", msg_done, 0);
                reset = 1'b1;
                aborted = 1;
            end else begin
                if (pending && fin_cnt == 0) begin
                    finished = FIN;
                    pending  = 0;
                end else begin
                    v = int'($urandom_range(0, 6));
                    finished = 3'((v >= 2) ? v + 1 : v);
                    if (pending) fin_cnt--;
                end
                if (ptr < nwords && int'($urandom_range(0, 99)) >= bub) begin
                    drive_word(ptr);
                    if (in_ready) ptr++;
                end else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        finished = '0;
        if (!aborted) begin
            check("msg_done_seen", dones, 1);
            @(negedge clk);
            check("done_pulse", msg_done, 0);
            check("idle_ready", in_ready, 1);
            check("idle_start", start, 0);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ready", in_ready, 0);
        check("rst_start", start, 0);
        check("rst_data", data, 0);
        check("rst_done", msg_done, 0);
        reset = 1'b1;
        @(negedge clk);
        check("idle_ready0", in_ready, 1);
        msg_q = '{8'h61, 8'h62, 8'h63};
        run_msg(-1, 0);
        make_msg(56);
        run_msg(-1, 20);
        make_msg(64);
        run_msg(-1, 20);
        make_msg(40);
        run_msg(8, 10);
        repeat (2) @(negedge clk);
        msg_q = '{8'h61, 8'h62, 8'h63};
        run_msg(-1, 0);
        for (int len = 52; len <= 65; len++) begin
            make_msg(len);
            run_msg(-1, 30);
        end
        for (int i = 0; i < 12; i++) begin
            make_msg(int'($urandom_range(1, 200)));
            run_msg(-1, 30);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
